fwd_hazard_ctrl: RTL

- Controller that sequences the operand-forwarding muxes of the 5-stage pipeline.
- Generates the 2-bit operand-A and operand-B forward selects for the EXE stage. Encoding: 00 = ID/EXE register data, 01 = MEM/WB write-back value, 10 = EXE/MEM ALU output.
- Detects load-use hazards and inserts a one-cycle bubble.
- Freezes the whole pipeline while a multi-cycle multiply occupies EXE.
- Keeps its own shadow copy of destination-register info for the EXE and MEM stages; sits beside the ID/EXE pipeline register.

---
 rtl/fwd_hazard_ctrl_pkg.sv | 20 ++
 rtl/fwd_hazard_ctrl_if.sv | 37 +++
 rtl/fwd_hazard_ctrl_sel.sv | 37 +++
 rtl/fwd_hazard_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the EXE-stage forwarding / hazard controller.
//   ASIZE     : register-address width used by every pipeline stage
//   DSIZE     : datapath width, shared with the rest of the core
//   FWD_*     : operand-mux select encodings for the EXE stage
//   state_e   : controller states (normal flow / multiply occupying EXE)
package fwd_hazard_ctrl_pkg;

  localparam int unsigned ASIZE = 5;
  localparam int unsigned DSIZE = 32;

  localparam logic [1:0] FWD_IDEXE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB  = 2'b01;
  localparam logic [1:0] FWD_EXEMEM = 2'b10;

  typedef enum logic {
    RUN,
    MUL_BUSY
  } state_e;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Bundle of the ID-stage decode info entering the controller and the control
// outputs it drives back into the pipeline.
//   master : pipeline side (drives ID fields, observes controls)
//   slave  : controller side
interface fwd_hazard_ctrl_if
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CSIZE = 16
);

  logic [ASIZE-1:0] rs_ID;
  logic [ASIZE-1:0] rt_ID;
  logic             rs_use_ID;
  logic             rt_use_ID;
  logic [ASIZE-1:0] rd_ID;
  logic             wen_ID;
  logic             memrd_ID;
  logic             mul_ID;
  logic             flush_ID;
  logic [1:0]       selA_EXE;
  logic [1:0]       selB_EXE;
  logic             stall_IF_ID;
  logic             bubble_ID_EXE;
  logic             freeze;
  logic [CSIZE-1:0] stall_cnt;

  modport master (
    output rs_ID, rt_ID, rs_use_ID, rt_use_ID, rd_ID, wen_ID, memrd_ID, mul_ID, flush_ID,
    input  selA_EXE, selB_EXE, stall_IF_ID, bubble_ID_EXE, freeze, stall_cnt
  );

  modport slave (
    input  rs_ID, rt_ID, rs_use_ID, rt_use_ID, rd_ID, wen_ID, memrd_ID, mul_ID, flush_ID,
    output selA_EXE, selB_EXE, stall_IF_ID, bubble_ID_EXE, freeze, stall_cnt
  );

endinterface

// File: rtl/fwd_hazard_ctrl_sel.sv
// fwd_sel_calc: priority compare of one source operand against the EXE and
// MEM destination shadows.
//   use_i, reg_i         : operand is read / its register address
//   exe_rd_i, exe_wen_i  : destination of the instruction now in EXE
//   mem_rd_i, mem_wen_i  : destination of the instruction now in MEM
//   sel_o                : forward select (EXE/MEM beats MEM/WB, r0 never)
//   match_exe_o          : operand depends on the EXE instruction
module fwd_sel_calc
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic             use_i,
  input  logic [ASIZE-1:0] reg_i,
  input  logic [ASIZE-1:0] exe_rd_i,
  input  logic             exe_wen_i,
  input  logic [ASIZE-1:0] mem_rd_i,
  input  logic             mem_wen_i,
  output logic [1:0]       sel_o,
  output logic             match_exe_o
);

  logic live;
  logic match_mem;

  assign live        = use_i && (reg_i != '0);
  assign match_exe_o = live && exe_wen_i && (exe_rd_i == reg_i);
  assign match_mem   = live && mem_wen_i && (mem_rd_i == reg_i);

  always_comb begin
    sel_o = FWD_IDEXE;
    if (match_exe_o) begin
      sel_o = FWD_EXEMEM;
    end else if (match_mem) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding-select, load-use stall and multiply-freeze
// controller sitting beside the ID/EXE pipeline register.
//   clk, rst_n : pipeline clock, asynchronous active-low reset
//   bus        : ID decode fields in; registered forward selects, stall,
//                bubble, freeze and saturating stall-cycle counter out
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CSIZE   = 16
) (
  input logic              clk,
  input logic              rst_n,
  fwd_hazard_ctrl_if.slave bus
);

  localparam int unsigned CntW     = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam bit          MulMulti = (MUL_LAT > 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ASIZE-1:0]  exe_rd_q, mem_rd_q;
  logic              exe_wen_q, exe_ld_q, exe_mul_q, mem_wen_q;
  logic [1:0]        sel_a_q, sel_b_q;
  logic [CSIZE-1:0]  stall_cnt_q;

  logic [1:0] sel_a_d, sel_b_d;
  logic       hit_exe_a, hit_exe_b;
  logic       ldhaz;
  logic       freeze, stall, bubble;

  fwd_sel_calc u_sel_a (
    .use_i       (bus.rs_use_ID),
    .reg_i       (bus.rs_ID),
    .exe_rd_i    (exe_rd_q),
    .exe_wen_i   (exe_wen_q),
    .mem_rd_i    (mem_rd_q),
    .mem_wen_i   (mem_wen_q),
    .sel_o       (sel_a_d),
    .match_exe_o (hit_exe_a)
  );

  fwd_sel_calc u_sel_b (
    .use_i       (bus.rt_use_ID),
    .reg_i       (bus.rt_ID),
    .exe_rd_i    (exe_rd_q),
    .exe_wen_i   (exe_wen_q),
    .mem_rd_i    (mem_rd_q),
    .mem_wen_i   (mem_wen_q),
    .sel_o       (sel_b_d),
    .match_exe_o (hit_exe_b)
  );

  assign ldhaz = exe_ld_q && (hit_exe_a || hit_exe_b);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    freeze  = 1'b0;
    stall   = 1'b0;
    bubble  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (exe_mul_q && MulMulti) begin
          freeze  = 1'b1;
          cnt_d   = CntW'(MUL_LAT - 2);
          state_d = MUL_BUSY;
        end else if (bus.flush_ID) begin
          bubble = 1'b1;
        end else if (ldhaz) begin
          stall  = 1'b1;
          bubble = 1'b1;
        end
      end
      MUL_BUSY: begin
        if (cnt_q == '0) begin
          // Release cycle: the multiply still sits in EXE but must not
          // re-trigger; normal hazard handling applies.
          state_d = RUN;
          if (bus.flush_ID) begin
            bubble = 1'b1;
          end else if (ldhaz) begin
            stall  = 1'b1;
            bubble = 1'b1;
          end
        end else begin
          freeze = 1'b1;
          cnt_d  = cnt_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      exe_rd_q    <= '0;
      exe_wen_q   <= 1'b0;
      exe_ld_q    <= 1'b0;
      exe_mul_q   <= 1'b0;
      mem_rd_q    <= '0;
      mem_wen_q   <= 1'b0;
      sel_a_q     <= FWD_IDEXE;
      sel_b_q     <= FWD_IDEXE;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!freeze) begin
        mem_rd_q  <= exe_rd_q;
        mem_wen_q <= exe_wen_q;
        if (bubble) begin
          exe_rd_q  <= '0;
          exe_wen_q <= 1'b0;
          exe_ld_q  <= 1'b0;
          exe_mul_q <= 1'b0;
          sel_a_q   <= FWD_IDEXE;
          sel_b_q   <= FWD_IDEXE;
        end else begin
          exe_rd_q  <= bus.rd_ID;
          exe_wen_q <= bus.wen_ID;
          exe_ld_q  <= bus.memrd_ID;
          exe_mul_q <= bus.mul_ID;
          sel_a_q   <= sel_a_d;
          sel_b_q   <= sel_b_d;
        end
      end
      if ((stall || freeze) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign bus.selA_EXE      = sel_a_q;
  assign bus.selB_EXE      = sel_b_q;
  assign bus.stall_IF_ID   = stall;
  assign bus.bubble_ID_EXE = bubble;
  assign bus.freeze        = freeze;
  assign bus.stall_cnt     = stall_cnt_q;

endmodule
